psm_regulator_nch: RTL and testbench

Multi-channel pulse-skipping regulator controller, parametrised in channel count and ADC width. Takes time-multiplexed ADC samples (value plus channel tag) and decides per channel whether to request an energy pulse. The decision uses a hysteresis window, an emergency boost path, and an over-voltage clamp with a hold timer. Adds phase-interleaved PWM gating, automatic load-sharing detection across channels and an optional per-channel reference soft-start; sits between the ADC sequencer front-end and the APSM power-stage drivers.

---
 rtl/psm_regulator_nch_pkg.sv | 32 +++
 rtl/psm_regulator_nch_if.sv | 31 +++
 rtl/psm_regulator_nch_pwm.sv | 26 ++
 rtl/psm_regulator_nch.sv | 174 +++++++++++++++++
 tb/tb_psm_regulator_nch.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/psm_regulator_nch_pkg.sv
// Shared types and defaults for the pulse-skipping regulator.
// State encoding, width helpers and default threshold constants.
package psm_pkg;

  typedef enum logic [1:0] {
    SOFT  = 2'd0,
    REG   = 2'd1,
    CLAMP = 2'd2,
    HOLD  = 2'd3
  } psm_state_t;

  localparam int DEF_NCH             = 2;
  localparam int DEF_ADC_W           = 12;
  localparam int DEF_RESOLUTION      = 9;
  localparam int DEF_DUTY            = 225;
  localparam int DEF_LOW_OFF         = 50;
  localparam int DEF_HIGH_OFF        = 50;
  localparam int DEF_EMERG_TH        = 600;
  localparam int DEF_EMERG_TH_SHARED = 300;
  localparam int DEF_OV_TH           = 180;
  localparam int DEF_HOLD_CYC        = 7;
  localparam int DEF_SS_STEP         = 16;

  function automatic int err_width(input int adc_w);
    return adc_w + 1;
  endfunction

  function automatic int chan_width(input int nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

endpackage

// File: rtl/psm_regulator_nch_if.sv
// Sample input and per-channel decision bus of the regulator.
// master drives samples and references, slave is the regulator.
interface psm_regulator_nch_if
  import psm_pkg::*;
#(
  parameter int NCH   = DEF_NCH,
  parameter int ADC_W = DEF_ADC_W
);
  localparam int EW = err_width(ADC_W);
  localparam int CW = chan_width(NCH);

  logic [ADC_W-1:0]     volt_in;
  logic [CW-1:0]        chan_in;
  logic                 drdy_in;
  logic [NCH*ADC_W-1:0] v_ref;
  logic [NCH-1:0]       psm_request;
  logic [NCH*EW-1:0]    error_out;
  logic [NCH-1:0]       emergency;
  logic [NCH-1:0]       clamp_active;
  logic                 load_sharing;

  modport master (
    output volt_in, chan_in, drdy_in, v_ref,
    input  psm_request, error_out, emergency, clamp_active, load_sharing
  );

  modport slave (
    input  volt_in, chan_in, drdy_in, v_ref,
    output psm_request, error_out, emergency, clamp_active, load_sharing
  );
endinterface

// File: rtl/psm_regulator_nch_pwm.sv
// Free-running PWM counter with one phase-shifted duty comparator per channel.
// Offsets spread channels evenly over the period so their pulses interleave.
module psm_pwm_phase #(
  parameter int NCH        = 2,
  parameter int RESOLUTION = 9,
  parameter int DUTY       = 225
) (
  input  logic           clk,
  input  logic           reset_in,
  output logic [NCH-1:0] pwm
);
  logic [RESOLUTION-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset_in) begin
    if (!reset_in) r_cnt <= '0;
    else           r_cnt <= r_cnt + 1'b1;
  end

  for (genvar c = 0; c < NCH; c++) begin : g_phase
    localparam logic [RESOLUTION-1:0] OFF = RESOLUTION'((c * (2 ** RESOLUTION)) / NCH);
    logic [RESOLUTION-1:0] w_phase;
    // Addition wraps naturally at the counter width, giving the modulo.
    assign w_phase = r_cnt + OFF;
    assign pwm[c]  = 32'(w_phase) < 32'(DUTY);
  end
endmodule

// File: rtl/psm_regulator_nch.sv
// Multi-channel pulse-skipping regulator: per-channel hysteresis, emergency boost, OV clamp+hold.
// Optional reference soft-start under PSM_SOFTSTART_EN; outputs registered one cycle after a sample.
module psm_regulator_nch
  import psm_pkg::*;
#(
  parameter int NCH             = DEF_NCH,
  parameter int ADC_W           = DEF_ADC_W,
  parameter int RESOLUTION      = DEF_RESOLUTION,
  parameter int DUTY            = DEF_DUTY,
  parameter int LOW_OFF         = DEF_LOW_OFF,
  parameter int HIGH_OFF        = DEF_HIGH_OFF,
  parameter int EMERG_TH        = DEF_EMERG_TH,
  parameter int EMERG_TH_SHARED = DEF_EMERG_TH_SHARED,
  parameter int OV_TH           = DEF_OV_TH,
  parameter int HOLD_CYC        = DEF_HOLD_CYC,
  parameter int SS_STEP         = DEF_SS_STEP
) (
  input logic               clk,
  input logic               reset_in,
  psm_regulator_nch_if.slave bus
);
  localparam int EW = err_width(ADC_W);
  localparam int TW = ADC_W + 2;
  localparam int CW = chan_width(NCH);
  localparam int HW = $clog2(HOLD_CYC + 2);

  localparam logic signed [TW-1:0] LO_T   = TW'(LOW_OFF);
  localparam logic signed [TW-1:0] HI_T   = TW'(HIGH_OFF);
  localparam logic signed [TW-1:0] OVV_T  = TW'(HIGH_OFF + 5);
  localparam logic signed [TW-1:0] OV_T   = TW'(OV_TH);
  localparam logic signed [TW-1:0] EM_T   = TW'(EMERG_TH);
  localparam logic signed [TW-1:0] EMS_T  = TW'(EMERG_TH_SHARED);
  localparam logic signed [TW-1:0] ZERO_T = '0;
`ifdef PSM_SOFTSTART_EN
  localparam psm_state_t RST_STATE = SOFT;
`else
  localparam psm_state_t RST_STATE = REG;
`endif

  logic [NCH-1:0] w_pwm;
  logic [NCH-1:0] w_reg_vec;
  logic           r_ls;

  psm_pwm_phase #(
    .NCH       (NCH),
    .RESOLUTION(RESOLUTION),
    .DUTY      (DUTY)
  ) u_pwm (
    .clk     (clk),
    .reset_in(reset_in),
    .pwm     (w_pwm)
  );

  // Built from registered flags, so it trails a flag change by one cycle.
  always_ff @(posedge clk or negedge reset_in) begin
    if (!reset_in) r_ls <= 1'b0;
    else           r_ls <= ($countones(w_reg_vec) >= 2);
  end
  assign bus.load_sharing = r_ls;

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    psm_state_t            r_state, w_state_nx;
    logic [HW-1:0]         r_hold, w_hold_nx;
    logic [ADC_W-1:0]      w_vref, w_ref_use;
    logic                  w_hit, w_ov, w_set, w_clr;
    logic                  w_reg_nx, w_emerg_nx, w_req_nx;
    logic signed [EW-1:0]  w_err;
    logic signed [TW-1:0]  w_err_t, w_ref_t, w_v_t, w_th;
    logic                  r_reg, r_emerg, r_req, r_clamp;
    logic [EW-1:0]         r_err;

    assign w_vref = bus.v_ref[c*ADC_W +: ADC_W];
    assign w_hit  = bus.drdy_in && (bus.chan_in == CW'(c));

`ifdef PSM_SOFTSTART_EN
    logic [ADC_W-1:0] r_ref_eff;
    logic [ADC_W:0]   w_ramp;
    // Ramp saturates at v_ref; a lowered v_ref pulls the reference down at once.
    assign w_ramp    = {1'b0, r_ref_eff} + (ADC_W+1)'(SS_STEP);
    assign w_ref_use = (r_state != SOFT) ? w_vref :
                       (w_ramp >= {1'b0, w_vref}) ? w_vref : w_ramp[ADC_W-1:0];

    always_ff @(posedge clk or negedge reset_in) begin
      if (!reset_in)  r_ref_eff <= '0;
      else if (w_hit) r_ref_eff <= (w_state_nx == SOFT) ? w_ref_use : w_vref;
    end
`else
    assign w_ref_use = w_vref;
`endif

    assign w_err   = $signed({1'b0, w_ref_use}) - $signed({1'b0, bus.volt_in});
    assign w_err_t = TW'(w_err);
    assign w_ref_t = $signed({2'b00, w_ref_use});
    assign w_v_t   = $signed({2'b00, bus.volt_in});
    assign w_ov    = (w_err_t < -OV_T) || (w_v_t > w_ref_t + OVV_T);
    assign w_set   = w_v_t < (w_ref_t - LO_T);
    assign w_clr   = w_v_t > (w_ref_t + HI_T);
    assign w_th    = (r_ls && (w_err_t > ZERO_T)) ? EMS_T : EM_T;

    always_comb begin
      w_state_nx = r_state;
      w_hold_nx  = r_hold;
      case (r_state)
        SOFT: begin
          if (w_ov)                         w_state_nx = CLAMP;
          else if (w_ref_use == w_vref)     w_state_nx = REG;
        end
        REG: begin
          if (w_ov) w_state_nx = CLAMP;
        end
        CLAMP: begin
          if (!w_ov) begin
            w_state_nx = HOLD;
            w_hold_nx  = HW'(HOLD_CYC);
          end
        end
        HOLD: begin
          if (w_ov) begin
            w_state_nx = CLAMP;
          end else if (r_hold <= HW'(1)) begin
            w_state_nx = REG;
            w_hold_nx  = '0;
          end else begin
            w_hold_nx  = r_hold - 1'b1;
          end
        end
        default: w_state_nx = RST_STATE;
      endcase

      w_reg_nx = r_reg;
      if (w_set)      w_reg_nx = 1'b1;
      else if (w_clr) w_reg_nx = 1'b0;
      if (w_state_nx != REG) w_reg_nx = 1'b0;

      w_emerg_nx = (w_err_t > w_th);
`ifdef PSM_SOFTSTART_EN
      if (w_state_nx == SOFT) w_emerg_nx = 1'b0;
`endif
      w_req_nx = (w_state_nx == REG) && ((w_pwm[c] && w_reg_nx) || w_emerg_nx);
    end

    always_ff @(posedge clk or negedge reset_in) begin
      if (!reset_in) begin
        r_state <= RST_STATE;
        r_hold  <= '0;
      end else if (w_hit) begin
        r_state <= w_state_nx;
        r_hold  <= w_hold_nx;
      end
    end

    always_ff @(posedge clk or negedge reset_in) begin
      if (!reset_in) begin
        r_reg   <= 1'b0;
        r_err   <= '0;
        r_emerg <= 1'b0;
        r_req   <= 1'b0;
        r_clamp <= 1'b0;
      end else if (w_hit) begin
        r_reg   <= w_reg_nx;
        r_err   <= w_err;
        r_emerg <= w_emerg_nx;
        r_req   <= w_req_nx;
        r_clamp <= (w_state_nx == CLAMP) || (w_state_nx == HOLD);
      end
    end

    assign w_reg_vec[c]                 = r_reg;
    assign bus.psm_request[c]           = r_req;
    assign bus.emergency[c]             = r_emerg;
    assign bus.clamp_active[c]          = r_clamp;
    assign bus.error_out[c*EW +: EW]    = r_err;
  end
endmodule

// File: tb/tb_psm_regulator_nch.sv
// Directed bench for psm_regulator_nch, three channels so an out-of-range tag is expressible.
module tb_psm_regulator_nch;
  import psm_pkg::*;

  localparam int NCH   = 3;
  localparam int ADC_W = 12;
  localparam int EW    = ADC_W + 1;
  localparam int CW    = 2;

  logic clk = 1'b0;
  logic reset_in = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   tb_cnt;

  always #5 clk = ~clk;

  psm_regulator_nch_if #(.NCH(NCH), .ADC_W(ADC_W)) bus ();

  psm_regulator_nch #(.NCH(NCH), .ADC_W(ADC_W)) dut (
    .clk     (clk),
    .reset_in(reset_in),
    .bus     (bus)
  );

  // Reference PWM counter: period 512, cleared by reset.
  always @(posedge clk or negedge reset_in) begin
    if (!reset_in) tb_cnt <= 0;
    else           tb_cnt <= (tb_cnt + 1) % 512;
  end

  function automatic bit pwm_exp(input int ch, input int cnt);
    return ((cnt + (ch * 512) / NCH) % 512) < 225;
  endfunction

  function automatic logic signed [EW-1:0] err_of(input int ch);
    return bus.error_out[ch*EW +: EW];
  endfunction

  task automatic do_reset();
    bus.drdy_in = 1'b0;
    bus.chan_in = '0;
    bus.volt_in = '0;
    bus.v_ref   = {3{12'd3150}};
    reset_in    = 1'b0;
    repeat (3) @(negedge clk);
    reset_in    = 1'b1;
  endtask

  task automatic sample(input int ch, input int v, output int cnt_at);
    @(negedge clk);
    bus.drdy_in = 1'b1;
    bus.chan_in = CW'(ch);
    bus.volt_in = ADC_W'(v);
    cnt_at      = tb_cnt;
    @(negedge clk);
    bus.drdy_in = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++; if (bus.psm_request !== 3'b000) begin errors++; $display("FAIL rst_req got=%b exp=000", bus.psm_request); end
    checks++; if (bus.error_out !== '0) begin errors++; $display("FAIL rst_err got=%h exp=0", bus.error_out); end
    checks++; if (bus.emergency !== 3'b000) begin errors++; $display("FAIL rst_emerg got=%b exp=000", bus.emergency); end
    checks++; if (bus.clamp_active !== 3'b000) begin errors++; $display("FAIL rst_clamp got=%b exp=000", bus.clamp_active); end
    checks++; if (bus.load_sharing !== 1'b0) begin errors++; $display("FAIL rst_ls got=%b exp=0", bus.load_sharing); end
  endtask

  task automatic test_regulation();
    int c;
    do_reset();
    for (int k = 0; k < 40; k++) begin
      repeat (13) @(negedge clk);
      sample(0, 3000, c);
      checks++;
      if (bus.psm_request[0] !== pwm_exp(0, c)) begin
        errors++; $display("FAIL reg_req k=%0d cnt=%0d got=%b exp=%b", k, c, bus.psm_request[0], pwm_exp(0, c));
      end
      checks++;
      if (err_of(0) !== EW'(150)) begin
        errors++; $display("FAIL reg_err k=%0d got=%0d exp=150", k, $signed(err_of(0)));
      end
    end
    checks++; if (bus.psm_request[1] !== 1'b0) begin errors++; $display("FAIL reg_other got=%b exp=0", bus.psm_request[1]); end
  endtask

  task automatic test_clamp();
    int c;
    sample(0, 3400, c);
    checks++; if (bus.clamp_active[0] !== 1'b1) begin errors++; $display("FAIL ov_clamp got=%b exp=1", bus.clamp_active[0]); end
    checks++; if (bus.psm_request[0] !== 1'b0) begin errors++; $display("FAIL ov_req got=%b exp=0", bus.psm_request[0]); end
    checks++; if (err_of(0) !== EW'(-250)) begin errors++; $display("FAIL ov_err got=%0d exp=-250", $signed(err_of(0))); end
    for (int i = 1; i <= 8; i++) begin
      sample(0, 3150, c);
      checks++;
      if (bus.clamp_active[0] !== (i < 8)) begin
        errors++; $display("FAIL hold_clamp i=%0d got=%b exp=%b", i, bus.clamp_active[0], (i < 8));
      end
      checks++;
      if (bus.psm_request[0] !== 1'b0) begin errors++; $display("FAIL hold_req i=%0d got=%b exp=0", i, bus.psm_request[0]); end
    end
    sample(0, 3205, c);
    checks++; if (bus.clamp_active[0] !== 1'b0) begin errors++; $display("FAIL ov_edge_lo got=%b exp=0", bus.clamp_active[0]); end
    sample(0, 3206, c);
    checks++; if (bus.clamp_active[0] !== 1'b1) begin errors++; $display("FAIL ov_edge_hi got=%b exp=1", bus.clamp_active[0]); end
    sample(0, 3150, c);
    sample(0, 3300, c);
    for (int i = 1; i <= 8; i++) begin
      sample(0, 3150, c);
      checks++;
      if (bus.clamp_active[0] !== (i < 8)) begin
        errors++; $display("FAIL reclamp i=%0d got=%b exp=%b", i, bus.clamp_active[0], (i < 8));
      end
    end
  endtask

  task automatic test_hysteresis();
    int c;
    do_reset();
    sample(0, 3100, c);
    checks++; if (bus.psm_request[0] !== 1'b0) begin errors++; $display("FAIL hyst_noset got=%b exp=0", bus.psm_request[0]); end
    sample(0, 3099, c);
    checks++; if (bus.psm_request[0] !== pwm_exp(0, c)) begin errors++; $display("FAIL hyst_set got=%b exp=%b", bus.psm_request[0], pwm_exp(0, c)); end
    sample(0, 3200, c);
    checks++; if (bus.psm_request[0] !== pwm_exp(0, c)) begin errors++; $display("FAIL hyst_keep got=%b exp=%b", bus.psm_request[0], pwm_exp(0, c)); end
    sample(0, 3201, c);
    checks++; if (bus.psm_request[0] !== 1'b0) begin errors++; $display("FAIL hyst_clr got=%b exp=0", bus.psm_request[0]); end
  endtask

  task automatic test_emergency();
    int c;
    do_reset();
    sample(1, 2549, c);
    checks++; if (bus.emergency[1] !== 1'b1) begin errors++; $display("FAIL em_601 got=%b exp=1", bus.emergency[1]); end
    checks++; if (bus.psm_request[1] !== 1'b1) begin errors++; $display("FAIL em_req got=%b exp=1", bus.psm_request[1]); end
    do_reset();
    sample(1, 2550, c);
    checks++; if (bus.emergency[1] !== 1'b0) begin errors++; $display("FAIL em_600 got=%b exp=0", bus.emergency[1]); end
    sample(1, 2800, c);
    checks++; if (bus.emergency[1] !== 1'b0) begin errors++; $display("FAIL em_single got=%b exp=0", bus.emergency[1]); end
    checks++; if (err_of(1) !== EW'(350)) begin errors++; $display("FAIL em_err got=%0d exp=350", $signed(err_of(1))); end
    sample(0, 3050, c);
    checks++; if (bus.load_sharing !== 1'b0) begin errors++; $display("FAIL ls_lag got=%b exp=0", bus.load_sharing); end
    @(negedge clk);
    checks++; if (bus.load_sharing !== 1'b1) begin errors++; $display("FAIL ls_set got=%b exp=1", bus.load_sharing); end
    sample(1, 2800, c);
    checks++; if (bus.emergency[1] !== 1'b1) begin errors++; $display("FAIL em_shared got=%b exp=1", bus.emergency[1]); end
    sample(1, 2850, c);
    checks++; if (bus.emergency[1] !== 1'b0) begin errors++; $display("FAIL em_sh300 got=%b exp=0", bus.emergency[1]); end
    sample(1, 2849, c);
    checks++; if (bus.emergency[1] !== 1'b1) begin errors++; $display("FAIL em_sh301 got=%b exp=1", bus.emergency[1]); end
  endtask

  task automatic test_back_to_back();
    int c0;
    logic [2:0] exp_req;
    do_reset();
    @(negedge clk);
    bus.drdy_in = 1'b1; bus.chan_in = 2'd0; bus.volt_in = 12'd3000; c0 = tb_cnt;
    @(negedge clk);
    bus.chan_in = 2'd1; bus.volt_in = 12'd3100;
    @(negedge clk);
    bus.chan_in = 2'd2; bus.volt_in = 12'd2900;
    @(negedge clk);
    bus.drdy_in = 1'b0;
    exp_req = {pwm_exp(2, (c0 + 2) % 512), 1'b0, pwm_exp(0, c0)};
    checks++; if (err_of(0) !== EW'(150)) begin errors++; $display("FAIL b2b_err0 got=%0d exp=150", $signed(err_of(0))); end
    checks++; if (err_of(1) !== EW'(50))  begin errors++; $display("FAIL b2b_err1 got=%0d exp=50", $signed(err_of(1))); end
    checks++; if (err_of(2) !== EW'(250)) begin errors++; $display("FAIL b2b_err2 got=%0d exp=250", $signed(err_of(2))); end
    checks++; if (bus.psm_request !== exp_req) begin errors++; $display("FAIL b2b_req got=%b exp=%b", bus.psm_request, exp_req); end
    @(negedge clk);
    checks++; if (bus.load_sharing !== 1'b1) begin errors++; $display("FAIL b2b_ls got=%b exp=1", bus.load_sharing); end
  endtask

  task automatic test_invalid_chan();
    int c;
    logic [NCH*EW-1:0] exp_err;
    logic [2:0] before_req;
    exp_err = {EW'(250), EW'(50), EW'(150)};
    before_req = bus.psm_request;
    sample(3, 0, c);
    repeat (2) @(negedge clk);
    checks++; if (bus.error_out !== exp_err) begin errors++; $display("FAIL inv_err got=%h exp=%h", bus.error_out, exp_err); end
    checks++; if (bus.emergency !== 3'b000) begin errors++; $display("FAIL inv_emerg got=%b exp=000", bus.emergency); end
    checks++; if (bus.clamp_active !== 3'b000) begin errors++; $display("FAIL inv_clamp got=%b exp=000", bus.clamp_active); end
    checks++; if (bus.psm_request !== before_req) begin errors++; $display("FAIL inv_req got=%b exp=%b", bus.psm_request, before_req); end
    checks++; if (bus.load_sharing !== 1'b1) begin errors++; $display("FAIL inv_ls got=%b exp=1", bus.load_sharing); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    bus.drdy_in = 1'b1; bus.chan_in = 2'd0; bus.volt_in = 12'd2000;
    #2 reset_in = 1'b0;
    #1;
    checks++; if (bus.psm_request !== 3'b000) begin errors++; $display("FAIL mid_req got=%b exp=000", bus.psm_request); end
    checks++; if (bus.error_out !== '0) begin errors++; $display("FAIL mid_err got=%h exp=0", bus.error_out); end
    checks++; if (bus.load_sharing !== 1'b0) begin errors++; $display("FAIL mid_ls got=%b exp=0", bus.load_sharing); end
    @(negedge clk);
    bus.drdy_in = 1'b0;
    checks++; if (bus.psm_request !== 3'b000) begin errors++; $display("FAIL mid_req2 got=%b exp=000", bus.psm_request); end
    checks++; if (bus.emergency !== 3'b000) begin errors++; $display("FAIL mid_emerg got=%b exp=000", bus.emergency); end
    reset_in = 1'b1;
  endtask

`ifdef PSM_SOFTSTART_EN
  task automatic test_softstart();
    int c;
    do_reset();
    bus.v_ref[11:0] = 12'd160;
    for (int k = 1; k <= 10; k++) begin
      sample(0, 0, c);
      checks++;
      if (err_of(0) !== EW'(16 * k)) begin errors++; $display("FAIL ss_err k=%0d got=%0d exp=%0d", k, $signed(err_of(0)), 16 * k); end
      if (k < 10) begin
        checks++;
        if (bus.psm_request[0] !== 1'b0) begin errors++; $display("FAIL ss_req k=%0d got=%b exp=0", k, bus.psm_request[0]); end
      end
    end
    sample(0, 0, c);
    checks++; if (err_of(0) !== EW'(160)) begin errors++; $display("FAIL ss_sat got=%0d exp=160", $signed(err_of(0))); end
  endtask
`else
  task automatic test_no_softstart();
    int c;
    do_reset();
    sample(0, 0, c);
    checks++; if (err_of(0) !== EW'(3150)) begin errors++; $display("FAIL nss_err got=%0d exp=3150", $signed(err_of(0))); end
    checks++; if (bus.emergency[0] !== 1'b1) begin errors++; $display("FAIL nss_emerg got=%b exp=1", bus.emergency[0]); end
    checks++; if (bus.psm_request[0] !== 1'b1) begin errors++; $display("FAIL nss_req got=%b exp=1", bus.psm_request[0]); end
  endtask
`endif

  initial begin
    test_reset();
    test_regulation();
    test_clamp();
    test_hysteresis();
    test_emergency();
    test_back_to_back();
    test_invalid_chan();
    test_reset_mid();
`ifdef PSM_SOFTSTART_EN
    test_softstart();
`else
    test_no_softstart();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
